// File: rtl/lcd_controller.sv
// Character-LCD write engine: power-up wait, fixed five-command init sequence, then
// one handshaked byte write at a time with SETUP -> PULSE -> HOLD -> WAIT panel timing.
module lcd_controller #(
  parameter int unsigned POWERUP_CYC = 750000,
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned EN_CYC      = 25,
  parameter int unsigned CMD_CYC     = 2500,
  parameter int unsigned CLR_CYC     = 100000
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       req,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       ready,
  output logic       done,
  output logic       init_done,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA
);

  localparam int unsigned P_PWR = (POWERUP_CYC == 0) ? 1 : POWERUP_CYC;
  localparam int unsigned P_SET = (SETUP_CYC == 0) ? 1 : SETUP_CYC;
  localparam int unsigned P_EN  = (EN_CYC == 0) ? 1 : EN_CYC;
  localparam int unsigned P_CMD = (CMD_CYC == 0) ? 1 : CMD_CYC;
  localparam int unsigned P_CLR = (CLR_CYC == 0) ? 1 : CLR_CYC;
  localparam int unsigned M1    = (P_PWR > P_CLR) ? P_PWR : P_CLR;
  localparam int unsigned M2    = (P_CMD > P_EN) ? P_CMD : P_EN;
  localparam int unsigned M3    = (M1 > M2) ? M1 : M2;
  localparam int unsigned P_MAX = (M3 > P_SET) ? M3 : P_SET;
  localparam int CW = ($clog2(P_MAX) > 20) ? $clog2(P_MAX) : 20;

  // Phases of N cycles load N-1 and advance when the counter reaches zero.
  localparam logic [CW-1:0] L_PWR = CW'(P_PWR - 1);
  localparam logic [CW-1:0] L_SET = CW'(P_SET - 1);
  localparam logic [CW-1:0] L_EN  = CW'(P_EN - 1);
  localparam logic [CW-1:0] L_CMD = CW'(P_CMD - 1);
  localparam logic [CW-1:0] L_CLR = CW'(P_CLR - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT_LOAD, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_step, w_step_nxt;
  logic          r_lcd_rs, w_rs_nxt;
  logic [7:0]    r_lcd_data, w_data_nxt;
  logic          r_lcd_en, w_en_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_done, w_done_nxt;
  logic          r_init_done, w_init_done_nxt;
  logic          w_cnt_zero;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      3'd3:    return 8'h06;
      3'd4:    return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  // Clear-display and return-home need the long post-transfer wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02));
  endfunction

  assign w_cnt_zero = (r_cnt == {CW{1'b0}});

  // Next state, counter and next values of the registered outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = w_cnt_zero ? r_cnt : (r_cnt - CW'(1));
    w_step_nxt      = r_step;
    w_rs_nxt        = r_lcd_rs;
    w_data_nxt      = r_lcd_data;
    w_init_done_nxt = r_init_done;
    case (r_state)
      S_PWRUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_INIT_LOAD;
        end else begin
          w_state_nxt = S_PWRUP;
        end
      end
      S_INIT_LOAD: begin
        w_rs_nxt    = 1'b0;
        w_data_nxt  = init_cmd(r_step);
        w_state_nxt = S_SETUP;
        w_cnt_nxt   = L_SET;
      end
      S_IDLE: begin
        if (req) begin
          w_rs_nxt    = req_rs;
          w_data_nxt  = req_data;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = L_SET;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = L_EN;
        end else begin
          w_state_nxt = S_SETUP;
        end
      end
      S_PULSE: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_state_nxt = S_PULSE;
        end
      end
      S_HOLD: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = is_slow_cmd(r_lcd_rs, r_lcd_data) ? L_CLR : L_CMD;
      end
      S_WAIT: begin
        if (w_cnt_zero) begin
          if (r_init_done) begin
            w_state_nxt = S_IDLE;
          end else if (r_step == 3'd4) begin
            w_state_nxt     = S_IDLE;
            w_init_done_nxt = 1'b1;
          end else begin
            w_step_nxt  = r_step + 3'd1;
            w_state_nxt = S_INIT_LOAD;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_PWRUP;
        w_cnt_nxt   = L_PWR;
      end
    endcase
    w_en_nxt    = (w_state_nxt == S_PULSE);
    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_done_nxt  = r_init_done && (w_state_nxt == S_WAIT) && (w_cnt_nxt == {CW{1'b0}});
  end

  // State register and registered outputs; reset restarts the whole init sequence.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      r_state     <= S_PWRUP;
      r_cnt       <= L_PWR;
      r_step      <= 3'd0;
      r_lcd_rs    <= 1'b0;
      r_lcd_data  <= 8'h00;
      r_lcd_en    <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_step      <= w_step_nxt;
      r_lcd_rs    <= w_rs_nxt;
      r_lcd_data  <= w_data_nxt;
      r_lcd_en    <= w_en_nxt;
      r_ready     <= w_ready_nxt;
      r_done      <= w_done_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign init_done = r_init_done;
  assign LCD_ON    = 1'b1;
  assign LCD_BLON  = 1'b1;
  assign LCD_RW    = 1'b0;
  assign LCD_RS    = r_lcd_rs;
  assign LCD_EN    = r_lcd_en;
  assign LCD_DATA  = r_lcd_data;

endmodule

// File: doc/lcd_controller.md
LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
- REQ-001: Parameter POWERUP_CYC, default 750000, power-up wait in clocks (15 ms at 50 MHz).
- REQ-002: Parameter SETUP_CYC, default 4, cycles RS/DATA are stable before LCD_EN rises.
- REQ-003: Parameter EN_CYC, default 25, cycles LCD_EN is held high (500 ns).
- REQ-004: Parameter CMD_CYC, default 2500, post-transfer wait for an ordinary command or data byte (50 us).
- REQ-005: Parameter CLR_CYC, default 100000, post-transfer wait after command 8'h01 or 8'h02 (2 ms).
- REQ-006: CLOCK_50  in  1  system clock; all logic on its rising edge.
- REQ-007: RST_N  in  1  reset; one clock, synchronous, active-low.
- REQ-008: req  in  1  write request, sampled only while ready=1.
- REQ-009: req_rs  in  1  register select for the request: 0 = command, 1 = character data.
- REQ-010: req_data  in  8  byte to write.
- REQ-011: ready  out  1  high when a request will be accepted this cycle.
- REQ-012: done  out  1  one-cycle pulse when an accepted request's wait has elapsed.
- REQ-013: init_done  out  1  high once the init sequence has completed; stays high until reset.
- REQ-014: LCD_ON, LCD_BLON  out  1 each  panel power and backlight, constant 1.
- REQ-015: LCD_RW  out  1  constant 0; the block only writes.
- REQ-016: LCD_RS, LCD_EN  out  1 each  registered panel register select and enable.
- REQ-017: LCD_DATA  out  8  registered panel data bus.

Function
- REQ-018: The FSM SHALL have states PWRUP, INIT_LOAD, IDLE, SETUP, PULSE, HOLD and WAIT, with one shared down-counter of at least 20 bits.
- REQ-019: PWRUP SHALL count POWERUP_CYC cycles and then go to INIT_LOAD.
- REQ-020: INIT_LOAD SHALL issue, in order, commands 8'h38, 8'h0C, 8'h01, 8'h06, 8'h80 with RS=0, each through SETUP->PULSE->HOLD->WAIT, using a 3-bit step index.
- REQ-021: After the WAIT of the fifth init command, the FSM SHALL go to IDLE and set init_done=1.
- REQ-022: ready SHALL be 1 only in IDLE; a req while ready=0 SHALL be ignored and not queued.
- REQ-023: When req=1 in IDLE, the block SHALL latch req_rs/req_data into LCD_RS/LCD_DATA on that edge and enter SETUP; ready SHALL drop on the next cycle.
- REQ-024: SETUP SHALL last SETUP_CYC cycles with LCD_EN=0.
- REQ-025: PULSE SHALL last EN_CYC cycles with LCD_EN=1.
- REQ-026: HOLD SHALL last 1 cycle with LCD_EN=0 and LCD_RS/LCD_DATA unchanged.
- REQ-027: WAIT SHALL last CLR_CYC cycles if RS=0 and DATA is 8'h01 or 8'h02, and CMD_CYC cycles otherwise.
- REQ-028: LCD_RS and LCD_DATA SHALL change only on entry to SETUP.
- REQ-029: done SHALL pulse on the last WAIT cycle of user requests only, never for init commands.
- REQ-030: Total latency from request acceptance to done SHALL be SETUP_CYC+EN_CYC+1+wait cycles; ready SHALL return to 1 on the cycle after done.
- REQ-031: Counter loads SHALL use the value N-1 and advance on reaching zero, so every phase is exactly N cycles; a parameter of 0 SHALL be treated as 1.
- REQ-032: LCD_EN SHALL never be high in any state except PULSE.

Reset
- REQ-033: With RST_N=0 at a rising edge, the FSM SHALL go to PWRUP with the counter reloaded.
- REQ-034: Reset values SHALL be LCD_EN=0, LCD_RS=0, LCD_DATA=8'h00, ready=0, done=0, init_done=0 and step index 0.
- REQ-035: Reset asserted mid-transfer (including during PULSE) SHALL drop LCD_EN on the same edge and restart the full init sequence.

Verification (parameters 20/2/3/5/10 unless noted)
- V1: Release reset, no req -> LCD_EN pulses exactly 5 times, DATA 38,0C,01,06,80 with RS=0; each EN-high run is 3 cycles; the gap after 01 is 10 cycles, others 5; init_done rises, ready=1.
- V2: After init, req with rs=1, data=8'h41 -> LCD_RS=1, LCD_DATA=41 next cycle; EN high 3 cycles starting 2 cycles later; done pulses 11 cycles after acceptance.
- V3: req rs=0, data=8'h01 -> WAIT lasts 10 cycles; done pulses 16 cycles after acceptance; no done pulses during init.
- V4: Hold req=1 continuously with changing data -> one transfer per ready window; bytes not sampled while ready=0 never appear on LCD_DATA.
- V5: Assert RST_N=0 for 1 cycle during PULSE -> LCD_EN=0 on that edge, init_done=0, and the full V1 sequence repeats.
- V6: Defaults with EN_CYC=0 -> EN-high runs are 1 cycle; LCD_RW=0, LCD_ON=1 and LCD_BLON=1 throughout.
